dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM between the multicycle CPU and a host/debug port
//  (program loader, result readback). Round-robin arbitration per cycle, optional host
//  lock for uninterrupted bursts, and a one-cycle read-return pipeline with owner tag.
//  Sits between RISCVCPU/host logic and the D_Memory RAM instance.
// PARAMETERS
//  AW      12  word-address width (covers M*N+N*N2+M*N2 words at defaults)
//  DW      32  data width
// PORTS
//  CLOCK_50     in   1   system clock; all state updates on rising edge
//  rst          in   1   asynchronous, active-high reset
//  cpu_req      in   1   CPU access request; hold with cpu_we/addr/wdata stable until cpu_gnt
//  cpu_we       in   1   1 = write, 0 = read
//  cpu_addr     in   AW  word address
//  cpu_wdata    in   DW  write data
//  cpu_gnt      out  1   access performed this cycle (combinational)
//  cpu_rvalid   out  1   cpu_rdata valid (one cycle after read grant)
//  cpu_rdata    out  DW  read data
//  host_req/host_we/host_addr/host_wdata/host_gnt/host_rvalid/host_rdata: same as cpu_*
//  host_lock    in   1   while high with host_req, host keeps ownership after its grant
//  mem_wr_en    out  1   RAM write enable
//  mem_index    out  AW  RAM word address
//  mem_entry    out  DW  RAM write data
//  mem_rdata    in   DW  RAM registered read data (valid the cycle after address)
// BEHAVIOUR
//  - State: last_owner (CPU/HOST), rd_pend (1b), rd_owner (1b), locked (1b).
//  - Reset: last_owner=HOST (CPU wins first tie), rd_pend=0, locked=0; all gnt,
//    rvalid, mem_wr_en = 0; rdata outputs = 0; mem_index/mem_entry = 0. Gnts forced 0
//    while rst high. Reset mid-access discards a pending read return (no rvalid).
//  - Grant (combinational from requests and state):
//    locked && host_req -> host; else only one req -> that one; both req -> the one
//    that is NOT last_owner; no req -> none, mem_wr_en=0, mem_index holds last value.
//  - Granted requester's we/addr/wdata drive mem_wr_en/mem_index/mem_entry same cycle;
//    RAM writes on that edge. Write latency 0 (complete at grant edge).
//  - On grant edge: last_owner <= winner; if read, rd_pend<=1, rd_owner<=winner,
//    else rd_pend<=0. No grant -> rd_pend<=0.
//  - Read return: cycle after a read grant, <owner>_rvalid=1 for exactly one cycle,
//    <owner>_rdata=mem_rdata registered-through; other port rvalid=0, rdata holds.
//  - Back-to-back: a new grant may issue in the rvalid cycle (full throughput,
//    one access per clock).
//  - locked <= host_gnt && host_lock; clears the first cycle host_lock or host_req is low.
//    CPU starves while locked; no timeout.
//  - Same-address write then read by different owners: read sees new data (RAM order).
//  - Requester deasserting req before gnt is legal; no state change.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs cpu_stall_cnt[31:0], host_stall_cnt[31:0];
//    each increments every cycle its req=1 and gnt=0, saturates at 32'hFFFF_FFFF,
//    reset to 0 by rst. Not defined: ports and counters absent, behaviour otherwise
//    identical.
// TESTING
//  - Reset: rst=1 mid-read -> next cycle all rvalid=0, gnt=0, mem_wr_en=0.
//  - Tie: cpu_req&host_req every cycle, reads addr 5/9 -> grants alternate CPU,HOST,
//    CPU...; cpu_rvalid/host_rvalid alternate one cycle later with RAM data.
//  - Host write 32'hDEAD_BEEF @ addr 3, next cycle CPU read addr 3 -> cpu_rvalid one
//    cycle later with cpu_rdata=32'hDEAD_BEEF.
//  - Lock: host_lock=1, host_req for 4 cycles, cpu_req held -> 4 host grants, then
//    cpu_gnt the cycle after host_lock drops.
//  - Single requester: cpu_req only, 10 reads -> cpu_gnt every cycle, 10 rvalids.
//  - DMEM_ARB_STATS_EN: CPU blocked 4 cycles by lock -> cpu_stall_cnt=4, host=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU and a host/debug port
// Round-robin per-cycle arbitration, host lock for bursts, one-cycle read return tagged by owner.
// Ports: CLOCK_50/rst (async, active high); cpu_* and host_* request ports (req/we/addr/wdata in,
// gnt/rvalid/rdata out); host_lock in; mem_wr_en/mem_index/mem_entry out, mem_rdata in.
// Build option DMEM_ARB_STATS_EN adds saturating stall counters cpu_stall_cnt/host_stall_cnt.
module dmem_arbiter #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          CLOCK_50,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   input  logic          host_lock,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_index,
   output logic [DW-1:0] mem_entry,
   input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]   cpu_stall_cnt,
   output logic [31:0]   host_stall_cnt
`endif
);
   typedef enum logic {CPU = 1'b0, HOST = 1'b1} owner_t;
   owner_t last_owner, rd_owner;
   logic rd_pend, locked, host_win;
   logic [AW-1:0] idx_q;
   logic [DW-1:0] entry_q, cpu_rdata_q, host_rdata_q;
   // Host wins when locked, when alone, or on a tie if the CPU went last.
   always_comb begin
      host_win = host_req && (locked || !cpu_req || last_owner == CPU);
      cpu_gnt = !rst && cpu_req && !host_win;
      host_gnt = !rst && host_win;
      mem_wr_en = cpu_gnt ? cpu_we : host_gnt && host_we;
      mem_index = cpu_gnt ? cpu_addr : host_gnt ? host_addr : idx_q;
      mem_entry = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : entry_q;
      cpu_rvalid = rd_pend && rd_owner == CPU;
      host_rvalid = rd_pend && rd_owner == HOST;
      cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
      host_rdata = host_rvalid ? mem_rdata : host_rdata_q;
   end
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         last_owner <= HOST;
         rd_owner <= CPU;
         rd_pend <= 1'b0;
         locked <= 1'b0;
         idx_q <= '0;
         entry_q <= '0;
         cpu_rdata_q <= '0;
         host_rdata_q <= '0;
      end else begin
         if (cpu_gnt || host_gnt) last_owner <= host_gnt ? HOST : CPU;
         rd_pend <= (cpu_gnt || host_gnt) && !mem_wr_en;
         rd_owner <= host_gnt ? HOST : CPU;
         locked <= host_gnt && host_lock;
         idx_q <= mem_index;
         entry_q <= mem_entry;
         cpu_rdata_q <= cpu_rdata;
         host_rdata_q <= host_rdata;
      end
   end
`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         cpu_stall_cnt <= '0;
         host_stall_cnt <= '0;
      end else begin
         cpu_stall_cnt <= cpu_stall_cnt + 32'(cpu_req && !cpu_gnt && !(&cpu_stall_cnt));
         host_stall_cnt <= host_stall_cnt + 32'(host_req && !host_gnt && !(&host_stall_cnt));
      end
   end
`endif
endmodule
